// File: rtl/counter_cu.sv
// Control unit for the up/down counter: merges button edges and UART command
// bytes into run/clear/mode events and sequences STOP/RUN/CLEAR.
module counter_cu (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_run,
   input  logic       i_btn_clear,
   input  logic       i_btn_mode,
   input  logic       i_rx_done,
   input  logic [7:0] i_rx_data,
   output logic       o_enable,
   output logic       o_clear,
   output logic       o_mode,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CLEAR = 2'b10,
      ST_BAD   = 2'b11
   } state_t;

   state_t r_state;
   state_t w_next;

   logic r_run_prev;
   logic r_clear_prev;
   logic r_mode_prev;
   logic r_mode;

   logic w_run_ev;
   logic w_clear_ev;
   logic w_mode_ev;

   // Accepts the upper-case ASCII letter or its lower-case twin.
   function automatic logic is_cmd(input logic [7:0] d, input logic [7:0] upper);
      return (d == upper) || (d == (upper | 8'h20));
   endfunction

   assign w_run_ev   = (i_btn_run   & ~r_run_prev)   | (i_rx_done & is_cmd(i_rx_data, 8'h52));
   assign w_clear_ev = (i_btn_clear & ~r_clear_prev) | (i_rx_done & is_cmd(i_rx_data, 8'h43));
   assign w_mode_ev  = (i_btn_mode  & ~r_mode_prev)  | (i_rx_done & is_cmd(i_rx_data, 8'h4D));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_prev   <= 1'b0;
         r_clear_prev <= 1'b0;
         r_mode_prev  <= 1'b0;
      end else begin
         r_run_prev   <= i_btn_run;
         r_clear_prev <= i_btn_clear;
         r_mode_prev  <= i_btn_mode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_STOP;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_mode  <= r_mode ^ w_mode_ev;
      end
   end

   // Clear outranks run; CLEAR always lasts one cycle and ignores events.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_STOP: begin
            if (w_clear_ev)    w_next = ST_CLEAR;
            else if (w_run_ev) w_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_clear_ev)    w_next = ST_CLEAR;
            else if (w_run_ev) w_next = ST_STOP;
         end
         ST_CLEAR: w_next = ST_STOP;
         default:  w_next = ST_STOP;
      endcase
   end

   assign o_enable = (r_state == ST_RUN);
   assign o_clear  = (r_state == ST_CLEAR);
   assign o_mode   = r_mode;
   assign o_state  = r_state;

endmodule

// File: tb/tb_counter_cu.sv
// Bench for counter_cu: directed scenarios followed by random stimulus, all
// checked against an event-level reference model of the control unit.
module tb_counter_cu;

   logic       clk;
   logic       rst;
   logic       i_btn_run;
   logic       i_btn_clear;
   logic       i_btn_mode;
   logic       i_rx_done;
   logic [7:0] i_rx_data;
   logic       o_enable;
   logic       o_clear;
   logic       o_mode;
   logic [1:0] o_state;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: 0 = stopped, 1 = running, 2 = clearing
   int   m_state;
   logic m_mode;
   logic m_prev_run, m_prev_clear, m_prev_mode;

   counter_cu dut (
      .clk        (clk),
      .rst        (rst),
      .i_btn_run  (i_btn_run),
      .i_btn_clear(i_btn_clear),
      .i_btn_mode (i_btn_mode),
      .i_rx_done  (i_rx_done),
      .i_rx_data  (i_rx_data),
      .o_enable   (o_enable),
      .o_clear    (o_clear),
      .o_mode     (o_mode),
      .o_state    (o_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state      = 0;
      m_mode       = 1'b0;
      m_prev_run   = 1'b0;
      m_prev_clear = 1'b0;
      m_prev_mode  = 1'b0;
   endtask

   function automatic bit byte_is(input logic [7:0] d, input byte c);
      return (d == 8'(c)) || (d == 8'(c + 8'd32));
   endfunction

   task automatic model_step();
      bit run_ev, clr_ev, mode_ev;
      run_ev  = (i_btn_run   && !m_prev_run)   || (i_rx_done && byte_is(i_rx_data, "R"));
      clr_ev  = (i_btn_clear && !m_prev_clear) || (i_rx_done && byte_is(i_rx_data, "C"));
      mode_ev = (i_btn_mode  && !m_prev_mode)  || (i_rx_done && byte_is(i_rx_data, "M"));
      if (m_state == 2)  m_state = 0;
      else if (clr_ev)   m_state = 2;
      else if (run_ev)   m_state = (m_state == 0) ? 1 : 0;
      if (mode_ev) m_mode = ~m_mode;
      m_prev_run   = i_btn_run;
      m_prev_clear = i_btn_clear;
      m_prev_mode  = i_btn_mode;
   endtask

   task automatic check_all(input string tag);
      logic [1:0] exp_state;
      exp_state = 2'(m_state);
      check({tag, ".state"},  8'(o_state),  8'(exp_state));
      check({tag, ".enable"}, 8'(o_enable), 8'(m_state == 1));
      check({tag, ".clear"},  8'(o_clear),  8'(m_state == 2));
      check({tag, ".mode"},   8'(o_mode),   8'(m_mode));
   endtask

   // One clock: model advances, DUT clocks, outputs sampled 1 time unit later.
   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
      i_rx_done = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #1;
      rst = 1'b0;
   endtask

   task automatic uart(input logic [7:0] b, input string tag);
      i_rx_done = 1'b1;
      i_rx_data = b;
      step(tag);
   endtask

   logic [7:0] byte_tab [8];
   int         sel;

   initial begin
      byte_tab = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D, 8'h41, 8'h00};
      rst = 1'b1;
      i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
      i_rx_done = 1'b0; i_rx_data = 8'h00;
      model_reset();
      #2;
      check("reset.state",  8'(o_state),  8'h00);
      check("reset.enable", 8'(o_enable), 8'h00);
      check("reset.clear",  8'(o_clear),  8'h00);
      check("reset.mode",   8'(o_mode),   8'h00);
      @(posedge clk); #1;
      rst = 1'b0;

      // Run button held 10 cycles: one event only, stays running
      i_btn_run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step("run_hold");
         check("run_hold.const", 8'(o_state), 8'h01);
      end
      i_btn_run = 1'b0;
      step("run_release");
      i_btn_run = 1'b1;
      step("run_second");
      check("run_second.const", 8'(o_state), 8'h00);
      i_btn_run = 1'b0;
      step("idle");

      // Clear from RUN lasts exactly one cycle
      i_btn_run = 1'b1;  step("to_run");
      i_btn_run = 1'b0;  step("in_run");
      i_btn_clear = 1'b1; step("clr_press");
      check("clr_press.const", 8'(o_clear), 8'h01);
      step("clr_after");
      check("clr_after.const", 8'(o_state), 8'h00);
      i_btn_clear = 1'b0; step("clr_idle");

      // UART commands: run, mode, then an ignored byte
      uart(8'h72, "uart_r");
      check("uart_r.const", 8'(o_state), 8'h01);
      uart(8'h6D, "uart_m");
      check("uart_m.const", 8'(o_mode), 8'h01);
      uart(8'h41, "uart_a");
      check("uart_a.const", 8'(o_state), 8'h01);
      uart(8'h52, "uart_stop");

      // Run and clear rising together from STOP: clear wins
      i_btn_run = 1'b1; i_btn_clear = 1'b1;
      step("both");
      check("both.const", 8'(o_state), 8'h02);
      step("both_after");
      check("both_after.const", 8'(o_state), 8'h00);
      i_btn_run = 1'b0; i_btn_clear = 1'b0;
      step("both_idle");

      // Button and UART mode events in the same cycle toggle once
      async_reset("mode_rst");
      i_btn_mode = 1'b1;
      i_rx_done = 1'b1; i_rx_data = 8'h4D;
      step("mode_both");
      check("mode_both.const", 8'(o_mode), 8'h01);
      i_btn_mode = 1'b0;
      step("mode_idle");

      // Async reset while running with mode set
      i_btn_run = 1'b1; step("pre_rst_run");
      i_btn_run = 1'b0; step("pre_rst_hold");
      check("pre_rst.const", 8'(o_state), 8'h01);
      #2;
      async_reset("mid_rst");
      check("mid_rst.state", 8'(o_state), 8'h00);
      check("mid_rst.mode",  8'(o_mode),  8'h00);

      // Button held through reset release counts as an edge
      i_btn_run = 1'b1;
      async_reset("held_rst");
      step("held_after");
      check("held_after.const", 8'(o_state), 8'h01);
      i_btn_run = 1'b0;
      step("held_idle");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         i_btn_run   = ($urandom_range(0, 3) == 0);
         i_btn_clear = ($urandom_range(0, 5) == 0);
         i_btn_mode  = ($urandom_range(0, 3) == 0);
         i_rx_done   = ($urandom_range(0, 2) == 0);
         sel = int'($urandom_range(0, 7));
         i_rx_data   = (sel == 7) ? 8'($urandom) : byte_tab[sel];
         if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
